// File: rtl/cnn_acc_adder.sv
// Two-stage signed lane adder with optional packet accumulation and a
// saturating or wrapping XLEN result held in a stall-aware output register.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

module cnn_acc_adder #(
  parameter int unsigned XLEN  = `CNN_XLEN,
  parameter int unsigned LANES = 4,
  parameter int unsigned SAT   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*XLEN-1:0] in_data,
  input  logic                  in_acc,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic                  out_ovf
);

  localparam int unsigned LG = $clog2(LANES);
  localparam int unsigned SW = XLEN + LG;
  localparam int unsigned TW = SW + 1;
  localparam int unsigned HW = TW - XLEN + 1;

  logic                   stall_c;
  logic signed [SW-1:0]   lane_sum_c;
  logic signed [TW-1:0]   t_c;
  logic        [HW-1:0]   hi_c;
  logic                   ovf_c;
  logic                   end_c;
  logic signed [XLEN-1:0] res_c;

  logic                   s1_valid_q, s1_valid_d;
  logic signed [SW-1:0]   s1_sum_q,   s1_sum_d;
  logic                   s1_acc_q,   s1_acc_d;
  logic                   s1_last_q,  s1_last_d;
  logic signed [XLEN-1:0] acc_q,      acc_d;
  logic                   stk_q,      stk_d;
  logic                   out_valid_q, out_valid_d;
  logic        [XLEN-1:0] out_data_q,  out_data_d;
  logic                   out_ovf_q,   out_ovf_d;

  assign stall_c   = out_valid_q && !out_ready;
  assign in_ready  = !stall_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Exact sum of all lanes; LG guard bits make it overflow-free
  always_comb begin
    lane_sum_c = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_sum_c = lane_sum_c + SW'($signed(in_data[k*XLEN +: XLEN]));
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_acc_d   = s1_acc_q;
    s1_last_d  = s1_last_q;
    if (!stall_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d  = lane_sum_c;
        s1_acc_d  = in_acc;
        s1_last_d = in_last;
      end
    end
  end

  // Accumulate, range-check against the XLEN signed range, then clamp or wrap
  always_comb begin
    t_c   = TW'(acc_q) + TW'(s1_sum_q);
    hi_c  = t_c[TW-1:XLEN-1];
    ovf_c = !((&hi_c) || !(|hi_c));
    if ((SAT != 0) && ovf_c) begin
      res_c = t_c[TW-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
    end else begin
      res_c = t_c[XLEN-1:0];
    end
    end_c = !s1_acc_q || s1_last_q;

    acc_d       = acc_q;
    stk_d       = stk_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (!stall_c) begin
      out_valid_d = 1'b0;
      if (s1_valid_q) begin
        if (end_c) begin
          out_valid_d = 1'b1;
          out_data_d  = res_c;
          out_ovf_d   = stk_q || ovf_c;
          acc_d       = '0;
          stk_d       = 1'b0;
        end else begin
          acc_d = res_c;
          stk_d = stk_q || ovf_c;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_acc_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      stk_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_acc_q    <= s1_acc_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      stk_q       <= stk_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: doc/cnn_acc_adder.md
CNN_ACC_ADDER -- requirements
Module: cnn_acc_adder

Interface
REQ-001 The block SHALL have parameter XLEN, default `CNN_XLEN (16), operand and result width in bits.
REQ-002 The block SHALL have parameter LANES, default 4, number of signed operands summed per beat; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL have parameter SAT, default 1: 1 = saturate the result, 0 = wrap (two's-complement truncation).
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 Port list (name  direction  width  meaning):
- clock  in  1  sole clock; rising edge.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  LANES*XLEN  signed operands; lane k is bits [k*XLEN +: XLEN].
- in_acc  in  1  1 = accumulate beats into a packet; 0 = each beat is a standalone sum.
- in_last  in  1  final beat of the packet; used only when in_acc=1.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  XLEN  signed packet result.
- out_ovf  out  1  saturation or wrap occurred anywhere in the packet.

Function
REQ-006 A beat SHALL be accepted only on a cycle where in_valid=1 and in_ready=1; an output SHALL be consumed only on a cycle where out_valid=1 and out_ready=1.
REQ-007 The block SHALL define the stall condition as out_valid=1 and out_ready=0; in_ready SHALL equal NOT stall (combinational); no pipeline register SHALL change while stalled.
REQ-008 Stage 1 SHALL register the exact lane sum at width XLEN+log2(LANES), together with valid, in_acc and in_last, one cycle after acceptance.
REQ-009 Stage 2 SHALL compute t = acc + s1_sum at full width, where acc is 0 on the first beat of a packet.
REQ-010 With SAT=1, stage 2 SHALL clamp t to [-2^(XLEN-1), 2^(XLEN-1)-1]; with SAT=0 it SHALL keep the low XLEN bits.
REQ-011 A beat SHALL be flagged as overflowing when t lies outside the XLEN signed range, for either SAT value.
REQ-012 The clamped or wrapped t SHALL become the new accumulator; out_ovf SHALL be the OR of all beat overflow flags in the packet.
REQ-013 A packet SHALL end on a beat where in_acc=0 or in_last=1.
- On the end beat, out_data and out_ovf SHALL load, out_valid SHALL rise, and the accumulator and overflow sticky flag SHALL clear.
- On a non-end beat, only the accumulator and sticky flag SHALL update, and no output SHALL be produced.
REQ-014 Latency from acceptance of the end beat to out_valid=1 SHALL be exactly 2 cycles when not stalled; throughput SHALL be one beat per cycle.
REQ-015 out_data and out_ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 If a result is consumed in the same cycle another end beat leaves stage 1, the new result SHALL load with no bubble.
REQ-017 Changing in_acc mid-packet is illegal; the block SHALL treat an in_acc=0 beat as an end beat.

Reset
REQ-018 While reset_n=0 at a rising edge, the block SHALL clear to 0: out_valid, out_data, out_ovf, the accumulator, the sticky flag, and stage-1 valid.
REQ-019 in_ready SHALL be 1 in the cycle following reset.
REQ-020 Reset asserted mid-packet SHALL discard the partial packet; the next accepted beat SHALL start a new packet from acc=0.

Verification (XLEN=16, LANES=4 unless noted)
REQ-021 Single beat, in_acc=0, lanes {0x00aa,0x0092,0,0} -> 2 cycles later out_data=0x013c, out_ovf=0.
REQ-022 Saturation, SAT=1: lanes {0x7000 x4} -> out_data=0x7fff, out_ovf=1; lanes {0x8000 x4} -> out_data=0x8000, out_ovf=1; lanes {0xfffd,0x00a0,0,0} -> out_data=0x009d, out_ovf=0.
REQ-023 Accumulate: 3 beats with in_acc=1, lanes {1,2,3,4}, in_last on beat 3 -> exactly one result, out_data=0x001e, out_ovf=0, 2 cycles after beat 3.
REQ-024 Backpressure: out_ready=0 for 3 cycles with a result pending -> out_data held and in_ready=0 for those cycles; streaming resumes with no beat lost or duplicated.
REQ-025 Reset mid-packet: 2 beats of in_acc=1 each summing 10, then reset_n=0 for 1 cycle, then 1 beat summing 5 with in_last=1 -> out_data=0x0005.
REQ-026 Wrap, SAT=0: lanes {0x7fff,0x0001,0,0} -> out_data=0x8000, out_ovf=1.
